// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions.
//   tx_state_e   transmitter FSM states
//   PAR_EVEN/ODD parity-type encodings, shared with the receiver
//   par_calc     parity bit from a reduction-xor and the parity type
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Even parity sends ^data, odd parity sends ~^data.
  function automatic logic par_calc(input logic red_xor, input logic par_typ);
    return (par_typ == PAR_ODD) ? ~red_xor : red_xor;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst     clock, synchronous active-high reset (flushes contents)
//   push, din    write request and data (ignored while full)
//   pop, dout    read request (ignored while empty) and head word
//   full, empty  occupancy flags
//   level        occupied entries
module uart_tx_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_WIDTH-1:0]         din,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic                  w_push;
  logic                  w_pop;

  assign full   = (r_count == (AW+1)'(FIFO_DEPTH));
  assign empty  = (r_count == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign dout   = r_mem[r_rd_ptr];
  assign level  = r_count;

  // Storage needs no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  // Power-of-two depth: pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter with TX FIFO and prescaler.
//   CLK, RST            clock, synchronous active-high reset
//   DATA_VALID, P_DATA  word write (accepted when DATA_READY)
//   DATA_READY          FIFO not full (combinational)
//   PAR_EN, PAR_TYP     parity enable, 0 even / 1 odd
//   STOP2               two stop bits when set
//   PRESCALE            bit period = PRESCALE+1 clocks
//   busy, S_DATA        frame in progress, serial line (idle high)
//   fifo_level          occupied FIFO entries
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          DATA_VALID,
  input  logic [DATA_WIDTH-1:0]         P_DATA,
  output logic                          DATA_READY,
  input  logic                          PAR_EN,
  input  logic                          PAR_TYP,
  input  logic                          STOP2,
  input  logic [PRESCALE_W-1:0]         PRESCALE,
  output logic                          busy,
  output logic                          S_DATA,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

  tx_state_e             r_state,    w_state_nxt;
  logic [PRESCALE_W-1:0] r_tmr,      w_tmr_nxt;
  logic [PRESCALE_W-1:0] r_prescale, w_prescale_nxt;
  logic [CW-1:0]         r_bitcnt,   w_bitcnt_nxt;
  logic [DATA_WIDTH-1:0] r_shift,    w_shift_nxt;
  logic                  r_stop_cnt, w_stop_cnt_nxt;
  logic                  r_par_bit,  w_par_bit_nxt;
  logic                  r_par_en,   w_par_en_nxt;
  logic                  r_stop2,    w_stop2_nxt;
  logic                  r_sdata,    w_sdata_nxt;
  logic                  r_busy;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_load;
  logic                  w_bit_end;
  logic [DATA_WIDTH-1:0] w_dout;

  uart_tx_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (CLK),
    .rst  (RST),
    .push (DATA_VALID),
    .pop  (w_pop),
    .din  (P_DATA),
    .dout (w_dout),
    .full (w_full),
    .empty(w_empty),
    .level(fifo_level)
  );

  assign DATA_READY = !w_full;
  assign busy       = r_busy;
  assign S_DATA     = r_sdata;
  assign w_bit_end  = (r_tmr == '0);

  // Next-state, datapath and line-level logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_tmr_nxt      = r_tmr;
    w_prescale_nxt = r_prescale;
    w_bitcnt_nxt   = r_bitcnt;
    w_shift_nxt    = r_shift;
    w_stop_cnt_nxt = r_stop_cnt;
    w_par_bit_nxt  = r_par_bit;
    w_par_en_nxt   = r_par_en;
    w_stop2_nxt    = r_stop2;
    w_sdata_nxt    = r_sdata;
    w_pop          = 1'b0;
    w_load         = 1'b0;

    if (r_state != ST_IDLE && !w_bit_end) w_tmr_nxt = r_tmr - PRESCALE_W'(1);

    case (r_state)
      ST_IDLE: w_load = !w_empty;
      ST_START: begin
        if (w_bit_end) begin
          w_state_nxt  = ST_DATA;
          w_tmr_nxt    = r_prescale;
          w_sdata_nxt  = r_shift[0];
          w_shift_nxt  = r_shift >> 1;
          w_bitcnt_nxt = '0;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_tmr_nxt = r_prescale;
          if (r_bitcnt == CW'(DATA_WIDTH - 1)) begin
            if (r_par_en) begin
              w_state_nxt = ST_PARITY;
              w_sdata_nxt = r_par_bit;
            end else begin
              w_state_nxt    = ST_STOP;
              w_sdata_nxt    = 1'b1;
              w_stop_cnt_nxt = 1'b0;
            end
          end else begin
            w_sdata_nxt  = r_shift[0];
            w_shift_nxt  = r_shift >> 1;
            w_bitcnt_nxt = r_bitcnt + CW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt    = ST_STOP;
          w_sdata_nxt    = 1'b1;
          w_tmr_nxt      = r_prescale;
          w_stop_cnt_nxt = 1'b0;
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          if (r_stop2 && !r_stop_cnt) begin
            w_stop_cnt_nxt = 1'b1;
            w_tmr_nxt      = r_prescale;
          end else if (!w_empty) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Frame start: pop head word and freeze config for the whole frame.
    if (w_load) begin
      w_pop          = 1'b1;
      w_state_nxt    = ST_START;
      w_tmr_nxt      = PRESCALE;
      w_prescale_nxt = PRESCALE;
      w_par_en_nxt   = PAR_EN;
      w_stop2_nxt    = STOP2;
      w_shift_nxt    = w_dout;
      w_par_bit_nxt  = par_calc(^w_dout, PAR_TYP);
      w_sdata_nxt    = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_tmr      <= '0;
      r_prescale <= '0;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_stop_cnt <= 1'b0;
      r_par_bit  <= 1'b0;
      r_par_en   <= 1'b0;
      r_stop2    <= 1'b0;
      r_sdata    <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tmr      <= w_tmr_nxt;
      r_prescale <= w_prescale_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_shift    <= w_shift_nxt;
      r_stop_cnt <= w_stop_cnt_nxt;
      r_par_bit  <= w_par_bit_nxt;
      r_par_en   <= w_par_en_nxt;
      r_stop2    <= w_stop2_nxt;
      r_sdata    <= w_sdata_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
    end
  end

endmodule
